// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states and iteration count.
package mdu_pkg;

    localparam int MDU_ITER = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } mdu_state_e;

    // MULT and DIV are signed; the low op bit marks the unsigned variants.
    function automatic logic mdu_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic mdu_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Unsigned shift-add multiply / restoring divide datapath, one bit per enabled cycle.
// hi/lo hold {partial product} or {remainder, quotient} depending on div_mode_i.
module mdu_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             iter_en_i,
    input  logic             div_mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] m_q;

    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic             cin;
    logic [WIDTH+1:0] sum;
    logic             carry;

    // Divide subtracts via the inverted operand plus carry-in; carry-out set means no borrow.
    always_comb begin
        add_a = {1'b0, hi_q};
        add_b = '0;
        cin   = 1'b0;
        if (div_mode_i) begin
            add_a = {hi_q, lo_q[WIDTH-1]};
            add_b = ~{1'b0, m_q};
            cin   = 1'b1;
        end else if (lo_q[0]) begin
            add_b = {1'b0, m_q};
        end
        sum   = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, cin};
        carry = sum[WIDTH+1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            m_q  <= '0;
        end else if (load_i) begin
            hi_q <= '0;
            lo_q <= div_mode_i ? a_i : b_i;
            m_q  <= div_mode_i ? b_i : a_i;
        end else if (iter_en_i) begin
            if (div_mode_i) begin
                hi_q <= carry ? sum[WIDTH-1:0] : add_a[WIDTH-1:0];
                lo_q <= {lo_q[WIDTH-2:0], carry};
            end else begin
                hi_q <= sum[WIDTH:1];
                lo_q <= {sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MTHI/MTLO writes.
// Optional macro MDU_FAST_ZERO_EN: multiplies with a zero operand finish straight from PREP.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mt_hi,
    input  logic             mt_lo,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    mdu_state_e       state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q;
    logic             rem_neg_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    logic             a_neg_d;
    logic             b_neg_d;
    logic [WIDTH-1:0] a_mag_d;
    logic [WIDTH-1:0] b_mag_d;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;
    logic [WIDTH-1:0] fix_hi_d;
    logic [WIDTH-1:0] fix_lo_d;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    always_comb begin
        a_neg_d = mdu_is_signed(op_q) & a_q[WIDTH-1];
        b_neg_d = mdu_is_signed(op_q) & b_q[WIDTH-1];
        a_mag_d = a_neg_d ? (~a_q) + ONE_W : a_q;
        b_mag_d = b_neg_d ? (~b_q) + ONE_W : b_q;
    end

    mdu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .load_i     (state_q == S_PREP),
        .iter_en_i  (state_q == S_RUN),
        .div_mode_i (mdu_is_div(op_q)),
        .a_i        (a_mag_d),
        .b_i        (b_mag_d),
        .hi_o       (core_hi),
        .lo_o       (core_lo)
    );

    // Sign correction on the unsigned magnitude result; remainder follows the dividend.
    always_comb begin
        prod     = {core_hi, core_lo};
        prod_neg = (~prod) + ONE_2W;
        if (mdu_is_div(op_q)) begin
            fix_lo_d = neg_q     ? (~core_lo) + ONE_W : core_lo;
            fix_hi_d = rem_neg_q ? (~core_hi) + ONE_W : core_hi;
        end else begin
            {fix_hi_d, fix_lo_d} = neg_q ? prod_neg : prod;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= MDU_MULT;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= A;
                        b_q     <= B;
                        busy_q  <= 1'b1;
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    neg_q     <= a_neg_d ^ b_neg_d;
                    rem_neg_q <= a_neg_d;
                    if (mdu_is_div(op_q) && (b_q == '0)) begin
                        hi_q    <= a_q;
                        lo_q    <= '1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
`ifdef MDU_FAST_ZERO_EN
                    end else if (!mdu_is_div(op_q) && ((a_q == '0) || (b_q == '0))) begin
                        hi_q    <= '0;
                        lo_q    <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
`endif
                    end else begin
                        cnt_q   <= CW'(ITER - 1);
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_FIX: begin
                    hi_q    <= fix_hi_d;
                    lo_q    <= fix_lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase

            // HI/LO are never written by the case arms in IDLE or DONE, so these cannot collide.
            if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
                if (mt_hi) hi_q <= mt_data;
                if (mt_lo) lo_q <= mt_data;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed-vector bench for mdu_seq: arithmetic results, latency, MTHI/MTLO, ignore and abort cases.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mt_hi;
    logic        mt_lo;
    logic [31:0] mt_data;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int vectors = 0;
    int miscompares = 0;

    mdu_seq #(.WIDTH(32), .ITER(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .A       (A),
        .B       (B),
        .mt_hi   (mt_hi),
        .mt_lo   (mt_lo),
        .mt_data (mt_data),
        .busy    (busy),
        .done    (done),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 clk = ~clk;

    // lat = edges from the start-sampling edge to the edge that first sees done high.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); A = $urandom; B = $urandom;
        lat = -1;
        bcnt = 0;
        for (int j = 0; j < 100; j++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = j + 1;
                break;
            end
            @(negedge clk);
        end
        $display("op=%0d A=%08h B=%08h -> HI=%08h LO=%08h lat=%0d busy=%0d", o, a, b, HI, LO, lat, bcnt);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy); miscompares++; end
        vectors++; if (done !== 1'b0) begin $display("FAIL reset_done got=%b exp=0", done); miscompares++; end
        vectors++; if (HI !== 32'h0) begin $display("FAIL reset_hi got=%08h exp=00000000", HI); miscompares++; end
        vectors++; if (LO !== 32'h0) begin $display("FAIL reset_lo got=%08h exp=00000000", LO); miscompares++; end
        reset = 1'b0;
    endtask

    task automatic test_multu();
        int lat, bc;
        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
        vectors++; if (HI !== 32'hFFFFFFFE) begin $display("FAIL multu_hi got=%08h exp=fffffffe", HI); miscompares++; end
        vectors++; if (LO !== 32'h00000001) begin $display("FAIL multu_lo got=%08h exp=00000001", LO); miscompares++; end
        vectors++; if (lat !== 35) begin $display("FAIL multu_latency got=%0d exp=35", lat); miscompares++; end
        vectors++; if (bc !== 34) begin $display("FAIL multu_busy_cycles got=%0d exp=34", bc); miscompares++; end
    endtask

    task automatic test_mult_signed();
        int lat, bc;
        run_op(2'd0, 32'hFFFFFFFD, 32'h00000007, lat, bc);
        vectors++; if (HI !== 32'hFFFFFFFF) begin $display("FAIL mult_hi got=%08h exp=ffffffff", HI); miscompares++; end
        vectors++; if (LO !== 32'hFFFFFFEB) begin $display("FAIL mult_lo got=%08h exp=ffffffeb", LO); miscompares++; end
        vectors++; if (lat !== 35) begin $display("FAIL mult_latency got=%0d exp=35", lat); miscompares++; end
    endtask

    task automatic test_div_overflow();
        int lat, bc;
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, lat, bc);
        vectors++; if (LO !== 32'h80000000) begin $display("FAIL divovf_lo got=%08h exp=80000000", LO); miscompares++; end
        vectors++; if (HI !== 32'h00000000) begin $display("FAIL divovf_hi got=%08h exp=00000000", HI); miscompares++; end
    endtask

    task automatic test_div_signed();
        int lat, bc;
        run_op(2'd2, 32'hFFFFFFF9, 32'h00000002, lat, bc);
        vectors++; if (LO !== 32'hFFFFFFFD) begin $display("FAIL div_lo got=%08h exp=fffffffd", LO); miscompares++; end
        vectors++; if (HI !== 32'hFFFFFFFF) begin $display("FAIL div_hi got=%08h exp=ffffffff", HI); miscompares++; end
        vectors++; if (lat !== 35) begin $display("FAIL div_latency got=%0d exp=35", lat); miscompares++; end
    endtask

    task automatic test_divu();
        int lat, bc;
        run_op(2'd3, 32'h00000010, 32'h00000003, lat, bc);
        vectors++; if (LO !== 32'h00000005) begin $display("FAIL divu_lo got=%08h exp=00000005", LO); miscompares++; end
        vectors++; if (HI !== 32'h00000001) begin $display("FAIL divu_hi got=%08h exp=00000001", HI); miscompares++; end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        run_op(2'd3, 32'h00001234, 32'h00000000, lat, bc);
        vectors++; if (HI !== 32'h00001234) begin $display("FAIL divu0_hi got=%08h exp=00001234", HI); miscompares++; end
        vectors++; if (LO !== 32'hFFFFFFFF) begin $display("FAIL divu0_lo got=%08h exp=ffffffff", LO); miscompares++; end
        vectors++; if (lat !== 2) begin $display("FAIL divu0_latency got=%0d exp=2", lat); miscompares++; end
        run_op(2'd2, 32'hFFFFFFF9, 32'h00000000, lat, bc);
        vectors++; if (HI !== 32'hFFFFFFF9) begin $display("FAIL div0_hi got=%08h exp=fffffff9", HI); miscompares++; end
        vectors++; if (lat !== 2) begin $display("FAIL div0_latency got=%0d exp=2", lat); miscompares++; end
    endtask

    task automatic test_ignore_during_run();
        int lat;
        @(negedge clk);
        op = 2'd1; A = 32'h00001234; B = 32'h00000010; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int j = 0; j < 100; j++) begin
            if (done) begin
                lat = j + 1;
                break;
            end
            start   = (j == 5);
            mt_hi   = (j == 5);
            mt_data = 32'hDEADBEEF;
            @(negedge clk);
        end
        start = 1'b0; mt_hi = 1'b0;
        $display("multu with start/mt_hi in RUN -> HI=%08h LO=%08h lat=%0d", HI, LO, lat);
        vectors++; if (lat !== 35) begin $display("FAIL ignore_latency got=%0d exp=35", lat); miscompares++; end
        vectors++; if (HI !== 32'h00000000) begin $display("FAIL ignore_hi got=%08h exp=00000000", HI); miscompares++; end
        vectors++; if (LO !== 32'h00012340) begin $display("FAIL ignore_lo got=%08h exp=00012340", LO); miscompares++; end
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin $display("FAIL ignore_no_restart got=%b exp=0", busy); miscompares++; end
    endtask

    task automatic test_mt_with_start();
        int lat;
        @(negedge clk);
        op = 2'd3; A = 32'h00000010; B = 32'h00000003; start = 1'b1;
        mt_hi = 1'b1; mt_data = 32'h00000077;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; mt_hi = 1'b0;
        vectors++; if (HI !== 32'h00000077) begin $display("FAIL mtstart_hi_lands got=%08h exp=00000077", HI); miscompares++; end
        lat = -1;
        for (int j = 0; j < 100; j++) begin
            if (done) begin
                lat = j + 1;
                break;
            end
            @(negedge clk);
        end
        $display("divu with coincident mt_hi -> HI=%08h LO=%08h lat=%0d", HI, LO, lat);
        vectors++; if (HI !== 32'h00000001) begin $display("FAIL mtstart_hi_final got=%08h exp=00000001", HI); miscompares++; end
        vectors++; if (LO !== 32'h00000005) begin $display("FAIL mtstart_lo_final got=%08h exp=00000005", LO); miscompares++; end
        vectors++; if (lat !== 35) begin $display("FAIL mtstart_latency got=%0d exp=35", lat); miscompares++; end
    endtask

    task automatic test_mt();
        repeat (2) @(negedge clk);
        mt_lo = 1'b1; mt_data = 32'h00000055;
        @(negedge clk);
        mt_lo = 1'b0;
        $display("mtlo 00000055 -> HI=%08h LO=%08h", HI, LO);
        vectors++; if (LO !== 32'h00000055) begin $display("FAIL mtlo_lo got=%08h exp=00000055", LO); miscompares++; end
        vectors++; if (HI !== 32'h00000001) begin $display("FAIL mtlo_hi_kept got=%08h exp=00000001", HI); miscompares++; end
        mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'h0000A5A5;
        @(negedge clk);
        mt_hi = 1'b0; mt_lo = 1'b0;
        $display("mthi+mtlo 0000a5a5 -> HI=%08h LO=%08h", HI, LO);
        vectors++; if (HI !== 32'h0000A5A5) begin $display("FAIL mtboth_hi got=%08h exp=0000a5a5", HI); miscompares++; end
        vectors++; if (LO !== 32'h0000A5A5) begin $display("FAIL mtboth_lo got=%08h exp=0000a5a5", LO); miscompares++; end
    endtask

    task automatic test_zero_operand();
        int lat, bc;
        int exp_lat;
`ifdef MDU_FAST_ZERO_EN
        exp_lat = 2;
`else
        exp_lat = 35;
`endif
        run_op(2'd0, 32'h00000000, 32'h00001234, lat, bc);
        vectors++; if (HI !== 32'h0) begin $display("FAIL zero_hi got=%08h exp=00000000", HI); miscompares++; end
        vectors++; if (LO !== 32'h0) begin $display("FAIL zero_lo got=%08h exp=00000000", LO); miscompares++; end
        vectors++; if (lat !== exp_lat) begin $display("FAIL zero_latency got=%0d exp=%0d", lat, exp_lat); miscompares++; end
    endtask

    task automatic test_reset_abort();
        int seen_done;
        // Leave nonzero HI/LO so the reset clear is observable.
        @(negedge clk);
        mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'h13572468;
        @(negedge clk);
        mt_hi = 1'b0; mt_lo = 1'b0;
        op = 2'd1; A = 32'hFFFFFFFF; B = 32'h00000003; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        vectors++; if (busy !== 1'b1) begin $display("FAIL abort_busy_before got=%b exp=1", busy); miscompares++; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("reset at RUN cycle 10 -> busy=%b done=%b HI=%08h LO=%08h", busy, done, HI, LO);
        vectors++; if (busy !== 1'b0) begin $display("FAIL abort_busy got=%b exp=0", busy); miscompares++; end
        vectors++; if (done !== 1'b0) begin $display("FAIL abort_done got=%b exp=0", done); miscompares++; end
        vectors++; if (HI !== 32'h0) begin $display("FAIL abort_hi got=%08h exp=00000000", HI); miscompares++; end
        vectors++; if (LO !== 32'h0) begin $display("FAIL abort_lo got=%08h exp=00000000", LO); miscompares++; end
        seen_done = 0;
        for (int j = 0; j < 40; j++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        vectors++; if (seen_done !== 0) begin $display("FAIL abort_no_done got=%0d exp=0", seen_done); miscompares++; end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'd0; A = '0; B = '0;
        mt_hi = 1'b0; mt_lo = 1'b0; mt_data = '0;
        test_reset();
        test_multu();
        test_mult_signed();
        test_div_overflow();
        test_div_signed();
        test_divu();
        test_div_zero();
        test_ignore_during_run();
        test_mt_with_start();
        test_mt();
        test_zero_operand();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
